// File: rtl/frame_sync_deserializer.sv
// Frame sync hunter and byte deserializer for the recovered CDR bit stream.
// Locks on SYNC_WORD, unpacks FRAME_BYTES payload bytes, flywheels through isolated sync errors.
module frame_sync_deserializer #(
    parameter int                   SYNC_BITS   = 8,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD   = 8'hD5,
    parameter int                   FRAME_BYTES = 16,
    parameter int                   LOSS_THRESH = 3
) (
    input  logic       clk_x8,
    input  logic       rst,
    input  logic       d_in,
    input  logic       d_in_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       sync_err,
    output logic       locked
);

    // One shift register serves both sync matching and byte assembly; it only
    // needs to remember the bits before the current one.
    localparam int SR_W = (SYNC_BITS > 8) ? SYNC_BITS : 8;
    localparam int BC_W = $clog2(FRAME_BYTES + 1);

    localparam logic [4:0]      FILL_FULL   = 5'(SYNC_BITS);
    localparam logic [4:0]      FILL_LAST   = 5'(SYNC_BITS - 1);
    localparam logic [3:0]      SYNC_LAST   = 4'(SYNC_BITS - 1);
    localparam logic [3:0]      THRESH_LAST = 4'(LOSS_THRESH - 1);
    localparam logic [BC_W-1:0] LAST_BYTE   = BC_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        SYNC_CHECK
    } state_e;

    state_e          state_q, state_d;
    logic [SR_W-2:0] shreg_q, shreg_d;
    logic [4:0]      fill_q, fill_d;
    logic [3:0]      bit_q, bit_d;
    logic [BC_W-1:0] bytec_q, bytec_d;
    logic [3:0]      miss_q, miss_d;
    logic [7:0]      byte_q, byte_d;
    logic            bv_q, bv_d;
    logic            fs_q, fs_d;
    logic            se_q, se_d;

    logic [SYNC_BITS-1:0] candidate;
    logic [7:0]           assembled;

    assign candidate = {shreg_q[SYNC_BITS-2:0], d_in};
    assign assembled = {shreg_q[6:0], d_in};

    always_ff @(posedge clk_x8) begin
        if (rst) begin
            state_q <= HUNT;
            shreg_q <= '0;
            fill_q  <= '0;
            bit_q   <= '0;
            bytec_q <= '0;
            miss_q  <= '0;
            byte_q  <= '0;
            bv_q    <= 1'b0;
            fs_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
            bit_q   <= bit_d;
            bytec_q <= bytec_d;
            miss_q  <= miss_d;
            byte_q  <= byte_d;
            bv_q    <= bv_d;
            fs_q    <= fs_d;
            se_q    <= se_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        fill_d  = fill_q;
        bit_d   = bit_q;
        bytec_d = bytec_q;
        miss_d  = miss_q;
        byte_d  = byte_q;
        bv_d    = 1'b0;
        fs_d    = 1'b0;
        se_d    = 1'b0;

        if (d_in_valid) begin
            shreg_d = {shreg_q[SR_W-3:0], d_in};
            case (state_q)
                HUNT: begin
                    if (fill_q != FILL_FULL) fill_d = fill_q + 5'd1;
                    // Fill guard stops bits left over from before HUNT forming a false match.
                    if (candidate == SYNC_WORD && fill_q >= FILL_LAST) begin
                        state_d = DATA;
                        fs_d    = 1'b1;
                        bit_d   = '0;
                        bytec_d = '0;
                    end
                end
                DATA: begin
                    if (bit_q == 4'd7) begin
                        byte_d = assembled;
                        bv_d   = 1'b1;
                        bit_d  = '0;
                        if (bytec_q == LAST_BYTE) begin
                            state_d = SYNC_CHECK;
                            bytec_d = '0;
                        end else begin
                            bytec_d = bytec_q + BC_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
                SYNC_CHECK: begin
                    if (bit_q == SYNC_LAST) begin
                        bit_d = '0;
                        if (candidate == SYNC_WORD) begin
                            miss_d  = '0;
                            fs_d    = 1'b1;
                            state_d = DATA;
                        end else if (miss_q == THRESH_LAST) begin
                            se_d    = 1'b1;
                            miss_d  = '0;
                            fill_d  = '0;
                            state_d = HUNT;
                        end else begin
                            miss_d  = miss_q + 4'd1;
                            se_d    = 1'b1;
                            fs_d    = 1'b1;
                            state_d = DATA;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked = (state_q != HUNT);
    end

    assign byte_out    = byte_q;
    assign byte_valid  = bv_q;
    assign frame_start = fs_q;
    assign sync_err    = se_q;

endmodule

// File: tb/tb_frame_sync_deserializer.sv
// Self-checking bench for frame_sync_deserializer: frame-level reference model
// predicts the ordered strobe events, a negedge monitor records what the DUT emits.
module tb_frame_sync_deserializer;

    localparam logic [7:0] SYNC  = 8'hD5;
    localparam int         NBYTE = 4;
    localparam int         LOSS  = 3;

    logic       clk_x8 = 1'b0;
    logic       rst = 1'b1;
    logic       d_in = 1'b0;
    logic       d_in_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       sync_err;
    logic       locked;

    int checks = 0;
    int fails = 0;

    // Event word: {frame_start, sync_err, byte_valid, byte, locked, preceded_by_valid}
    logic [12:0] obsQ[$];
    logic [12:0] expQ[$];
    logic        prevValid = 1'b0;

    bit randGap = 1'b0;
    bit lockedM = 1'b0;
    int missM = 0;

    frame_sync_deserializer #(
        .SYNC_BITS(8),
        .SYNC_WORD(8'hD5),
        .FRAME_BYTES(NBYTE),
        .LOSS_THRESH(LOSS)
    ) dut (
        .clk_x8(clk_x8),
        .rst(rst),
        .d_in(d_in),
        .d_in_valid(d_in_valid),
        .byte_out(byte_out),
        .byte_valid(byte_valid),
        .frame_start(frame_start),
        .sync_err(sync_err),
        .locked(locked)
    );

    always #5 clk_x8 = ~clk_x8;

    always @(posedge clk_x8) prevValid <= d_in_valid & ~rst;

    always @(negedge clk_x8) begin
        if (byte_valid || frame_start || sync_err)
            obsQ.push_back({frame_start, sync_err, byte_valid,
                            (byte_valid ? byte_out : 8'h00), locked, prevValid});
    end

    task automatic expEvent(input logic fs, input logic se, input logic bv,
                            input logic [7:0] d, input logic lk);
        expQ.push_back({fs, se, bv, d, lk, 1'b1});
    endtask

    task automatic send_bit(input logic b);
        int gap;
        gap = randGap ? int'($urandom_range(1, 20)) : 8;
        d_in = b;
        d_in_valid = 1'b1;
        @(negedge clk_x8);
        d_in_valid = 1'b0;
        repeat (gap - 1) @(negedge clk_x8);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Frame-level model: what a sync word does to lock state, then which bytes appear.
    task automatic send_frame(input logic [7:0] sw, input logic [31:0] payload, input bit withPayload);
        send_byte(sw);
        if (!lockedM) begin
            lockedM = 1'b1;
            missM = 0;
            expEvent(1, 0, 0, 8'h00, 1);
        end else if (sw == SYNC) begin
            missM = 0;
            expEvent(1, 0, 0, 8'h00, 1);
        end else if (missM + 1 < LOSS) begin
            missM++;
            expEvent(1, 1, 0, 8'h00, 1);
        end else begin
            missM = 0;
            lockedM = 1'b0;
            expEvent(0, 1, 0, 8'h00, 0);
        end
        if (withPayload) begin
            for (int k = 0; k < NBYTE; k++) begin
                send_byte(payload[31 - 8*k -: 8]);
                if (lockedM) expEvent(0, 0, 1, payload[31 - 8*k -: 8], 1);
            end
        end
    endtask

    task automatic send_junk(input int nbits, input logic first);
        logic b;
        b = first;
        for (int i = 0; i < nbits; i++) begin
            send_bit(b);
            b = ~b;
        end
    endtask

    function automatic logic [7:0] badSync();
        logic [7:0] s;
        s = 8'($urandom);
        if (s == SYNC) s = s ^ 8'h01;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) @(negedge clk_x8);
        rst = 1'b0;
        repeat (3) @(negedge clk_x8);
        checks++; if (byte_out !== 8'h00) begin fails++; $display("[TB] FAIL reset byte_out: got %h, expected 00", byte_out); end
        checks++; if (byte_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset byte_valid: got %b, expected 0", byte_valid); end
        checks++; if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL reset frame_start: got %b, expected 0", frame_start); end
        checks++; if (sync_err !== 1'b0) begin fails++; $display("[TB] FAIL reset sync_err: got %b, expected 0", sync_err); end
        checks++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL reset locked: got %b, expected 0", locked); end
        obsQ.delete();
    endtask

    task automatic test_lock_and_bytes();
        send_junk(20, 1'b1);
        send_frame(SYNC, 32'h12345678, 1);
        repeat (10) @(negedge clk_x8);
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL lock event count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                fails++;
                $display("[TB] FAIL lock event %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_back_to_back();
        send_frame(SYNC, 32'h9ABCDEF0, 1);
        repeat (10) @(negedge clk_x8);
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL b2b event count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                fails++;
                $display("[TB] FAIL b2b event %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_flywheel();
        send_frame(8'hD4, $urandom, 1);
        send_frame(SYNC, $urandom, 1);
        for (int n = 0; n < 3; n++) begin
            send_frame(badSync(), $urandom, 1);
            send_frame(SYNC, $urandom, 1);
        end
        repeat (10) @(negedge clk_x8);
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL flywheel event count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                fails++;
                $display("[TB] FAIL flywheel event %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    // The final bad sync 0x0D leaves stale bits that, with the next four hunt
    // bits 0101, spell D5 -- too few fresh bits, so no lock may happen there.
    task automatic test_loss_of_lock();
        send_frame(8'h00, $urandom, 1);
        send_frame(8'h00, $urandom, 1);
        send_frame(8'h0D, 32'h0, 0);
        checks++;
        if (locked !== 1'b0) begin fails++; $display("[TB] FAIL loss locked: got %b, expected 0", locked); end
        send_byte(8'h55);
        send_byte(8'h55);
        send_frame(SYNC, $urandom, 1);
        repeat (10) @(negedge clk_x8);
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL loss event count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                fails++;
                $display("[TB] FAIL loss event %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_random_gaps_and_reset();
        logic [7:0] b;
        rst = 1'b1;
        repeat (2) @(negedge clk_x8);
        rst = 1'b0;
        lockedM = 1'b0;
        missM = 0;
        obsQ.delete(); expQ.delete();
        randGap = 1'b1;
        send_junk(20, 1'b1);
        send_frame(SYNC, $urandom, 1);
        send_frame(SYNC, 32'h0, 0);
        b = 8'($urandom);
        send_byte(b);
        expEvent(0, 0, 1, b, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk_x8);
        rst = 1'b0;
        lockedM = 1'b0;
        missM = 0;
        checks++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL midreset locked: got %b, expected 0", locked); end
        checks++; if (byte_out !== 8'h00) begin fails++; $display("[TB] FAIL midreset byte_out: got %h, expected 00", byte_out); end
        checks++; if (byte_valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset byte_valid: got %b, expected 0", byte_valid); end
        send_junk(8, 1'b1);
        send_frame(SYNC, $urandom, 1);
        repeat (25) @(negedge clk_x8);
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL gaps event count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                fails++;
                $display("[TB] FAIL gaps event %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        obsQ.delete(); expQ.delete();
        randGap = 1'b0;
    endtask

    initial begin
        test_reset();
        @(negedge clk_x8);
        test_lock_and_bytes();
        test_back_to_back();
        test_flywheel();
        test_loss_of_lock();
        test_random_gaps_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
